// File: rtl/kc705_eth_frame_pkg.sv
// kc705_eth_frame_pkg: state encoding, field lengths and MAC defaults for the RGMII TX frame encoder
package kc705_eth_frame_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, SIZE, COUNTER, DATA, DRAIN, GAP} tx_state_t;
  localparam int HDR_LEN_NOVLAN = 12;
  localparam int HDR_LEN_VLAN = 16;
  localparam int SIZE_LEN = 2;
  localparam int CTR_LEN = 2;
  localparam logic [15:0] VLAN_TPID = 16'h8100;
  localparam logic [47:0] DEF_DEST_ADDR = 48'hda0102030405;
  localparam logic [47:0] DEF_SRC_ADDR = 48'h5a0102030405;
endpackage

// File: rtl/kc705_axis_byte_reg_slice.sv
// kc705_axis_byte_reg_slice: registered 8-bit data+last AXI-Stream stage; ports in_* (upstream beat, in_ready), out_* (registered beat, out_ready)
module kc705_axis_byte_reg_slice (
  input  logic       axi_tclk,
  input  logic       axi_tresetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready
);
  assign in_ready = !out_valid | out_ready;
  always_ff @(posedge axi_tclk or negedge axi_tresetn)
    if (!axi_tresetn) begin
      out_valid <= 1'b0;
      out_data <= 8'h00;
      out_last <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
endmodule

// File: rtl/kc705_ethernet_rgmii_axi_tx_encoder.sv
// kc705_ethernet_rgmii_axi_tx_encoder: builds dest/src/size/counter/payload frames onto the MAC TX AXI-Stream; ports: descriptor (desc_*), payload in (s_axis_*), frame out (tx_axis_*), status (frame_count, len_err, busy); TX_ENCODER_VLAN_EN inserts an 802.1Q tag
module kc705_ethernet_rgmii_axi_tx_encoder
  import kc705_eth_frame_pkg::*;
#(
  parameter logic [47:0] DEST_ADDR = DEF_DEST_ADDR,
  parameter logic [47:0] SRC_ADDR = DEF_SRC_ADDR,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1024,
  parameter int GAP_CYCLES = 12
) (
  input  logic        axi_tclk,
  input  logic        axi_tresetn,
  input  logic        enable_tx_encode,
  input  logic [15:0] desc_len,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic [15:0] frame_count,
  output logic        len_err,
  output logic        busy
);
`ifdef TX_ENCODER_VLAN_EN
  localparam logic [11:0] VLAN_ID = 12'd2;
  localparam logic [2:0] VLAN_PRIORITY = 3'd2;
  localparam int HDR_LEN = HDR_LEN_VLAN;
  localparam logic [8*HDR_LEN-1:0] HDR = {DEST_ADDR, SRC_ADDR, VLAN_TPID, VLAN_PRIORITY, 1'b0, VLAN_ID};
`else
  localparam int HDR_LEN = HDR_LEN_NOVLAN;
  localparam logic [8*HDR_LEN-1:0] HDR = {DEST_ADDR, SRC_ADDR};
`endif
  tx_state_t state, state_nx;
  logic [3:0] idx;
  logic [15:0] len, byte_cnt, frame_cnt;
  logic [7:0] gap_cnt, hdr_byte, emit_data;
  logic padding, slot_ready, emit, emit_last;
  logic field_end, data_last, desc_fire, hdr_fire, data_fire, drain_fire;
  assign hdr_byte = 8'(HDR >> (8 * (HDR_LEN - 1 - int'(idx))));
  assign field_end = idx == (state == HEADER ? 4'(HDR_LEN - 1) : state == COUNTER ? 4'(CTR_LEN - 1) : 4'(SIZE_LEN - 1));
  assign data_last = byte_cnt == len - 16'd1;
  assign desc_fire = desc_ready & desc_valid;
  assign hdr_fire = emit & (state != DATA);
  assign data_fire = emit & (state == DATA);
  assign drain_fire = (state == DRAIN) & s_axis_tvalid;
  assign busy = state != IDLE;
  assign frame_count = frame_cnt;
  always_ff @(posedge axi_tclk or negedge axi_tresetn)
    if (!axi_tresetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = desc_fire ? HEADER : IDLE;
      HEADER:  state_nx = hdr_fire & field_end ? SIZE : HEADER;
      SIZE:    state_nx = hdr_fire & field_end ? COUNTER : SIZE;
      COUNTER: state_nx = hdr_fire & field_end ? (len == 16'd0 ? GAP : DATA) : COUNTER;
      DATA:    state_nx = data_fire & data_last ? (padding | s_axis_tlast ? GAP : DRAIN) : DATA;
      DRAIN:   state_nx = drain_fire & s_axis_tlast ? GAP : DRAIN;
      GAP:     state_nx = !tx_axis_tvalid & (gap_cnt == 8'(GAP_CYCLES - 1)) ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  // desc_ready is gated by reset so it falls with the asynchronous reset, not a clock edge
  always_comb begin
    desc_ready = (state == IDLE) & enable_tx_encode & axi_tresetn;
    s_axis_tready = ((state == DATA) & !padding & slot_ready) | (state == DRAIN);
    emit = 1'b0;
    emit_data = 8'h00;
    emit_last = 1'b0;
    case (state)
      HEADER: begin
        emit = slot_ready;
        emit_data = hdr_byte;
      end
      SIZE: begin
        emit = slot_ready;
        emit_data = idx[0] ? len[15:8] : len[7:0];
      end
      COUNTER: begin
        emit = slot_ready;
        emit_data = idx[0] ? frame_cnt[15:8] : frame_cnt[7:0];
        emit_last = idx[0] & (len == 16'd0);
      end
      DATA: begin
        emit = slot_ready & (padding | s_axis_tvalid);
        emit_data = padding ? 8'h00 : s_axis_tdata;
        emit_last = data_last;
      end
      default: emit = 1'b0;
    endcase
  end
  // gap only counts once the last byte has left the output register
  always_ff @(posedge axi_tclk or negedge axi_tresetn)
    if (!axi_tresetn) begin
      idx <= 4'd0;
      len <= 16'd0;
      byte_cnt <= 16'd0;
      padding <= 1'b0;
      len_err <= 1'b0;
      gap_cnt <= 8'd0;
      frame_cnt <= 16'd0;
    end else begin
      if (desc_fire) begin
        len <= desc_len > MAX_PAYLOAD ? MAX_PAYLOAD : desc_len;
        byte_cnt <= 16'd0;
        padding <= 1'b0;
        idx <= 4'd0;
      end
      if (hdr_fire) idx <= field_end ? 4'd0 : idx + 4'd1;
      if (data_fire) byte_cnt <= byte_cnt + 16'd1;
      if (data_fire & !padding & s_axis_tlast & !data_last) padding <= 1'b1;
      if ((desc_fire & (desc_len > MAX_PAYLOAD)) | (data_fire & !padding & (s_axis_tlast != data_last))) len_err <= 1'b1;
      gap_cnt <= state != GAP ? 8'd0 : !tx_axis_tvalid ? gap_cnt + 8'd1 : gap_cnt;
      if (tx_axis_tvalid & tx_axis_tready & tx_axis_tlast) frame_cnt <= frame_cnt + 16'd1;
    end
  kc705_axis_byte_reg_slice u_slice (
    .axi_tclk    (axi_tclk),
    .axi_tresetn (axi_tresetn),
    .in_valid    (emit),
    .in_data     (emit_data),
    .in_last     (emit_last),
    .in_ready    (slot_ready),
    .out_data    (tx_axis_tdata),
    .out_last    (tx_axis_tlast),
    .out_valid   (tx_axis_tvalid),
    .out_ready   (tx_axis_tready)
  );
endmodule

// File: tb/tb_kc705_ethernet_rgmii_axi_tx_encoder.sv
// tb_kc705_ethernet_rgmii_axi_tx_encoder: directed self-checking bench for the TX frame encoder
module tb_kc705_ethernet_rgmii_axi_tx_encoder;
  logic axi_tclk = 1'b0;
  logic axi_tresetn = 1'b0;
  logic enable_tx_encode = 1'b1;
  logic [15:0] desc_len = 16'd0;
  logic desc_valid = 1'b0;
  logic desc_ready;
  logic [7:0] s_axis_tdata = 8'h00;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tlast = 1'b0;
  logic s_axis_tready;
  logic [7:0] tx_axis_tdata;
  logic tx_axis_tvalid;
  logic tx_axis_tlast;
  logic tx_axis_tready = 1'b1;
  logic [15:0] frame_count;
  logic len_err;
  logic busy;
  int checks = 0;
  int failures = 0;
  logic [8:0] src_q[$];
  logic [8:0] out_q[$];
  logic [8:0] exp_q[$];
  int sink_mode = 0;
  int frames_done = 0;
  int stall_err = 0;
  int last_gap = 0;
  kc705_ethernet_rgmii_axi_tx_encoder dut (
    .axi_tclk         (axi_tclk),
    .axi_tresetn      (axi_tresetn),
    .enable_tx_encode (enable_tx_encode),
    .desc_len         (desc_len),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tready    (s_axis_tready),
    .tx_axis_tdata    (tx_axis_tdata),
    .tx_axis_tvalid   (tx_axis_tvalid),
    .tx_axis_tlast    (tx_axis_tlast),
    .tx_axis_tready   (tx_axis_tready),
    .frame_count      (frame_count),
    .len_err          (len_err),
    .busy             (busy)
  );
  always #5 axi_tclk = ~axi_tclk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin : source
    logic fire;
    forever begin
      @(negedge axi_tclk);
      fire = s_axis_tvalid & s_axis_tready;
      @(posedge axi_tclk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      s_axis_tvalid = src_q.size() > 0;
      {s_axis_tlast, s_axis_tdata} = src_q.size() > 0 ? src_q[0] : 9'h000;
    end
  end
  initial begin : sink
    logic stalled, gap_on;
    logic [8:0] held;
    int idle_run;
    stalled = 1'b0;
    gap_on = 1'b0;
    held = 9'h000;
    idle_run = 0;
    forever begin
      @(negedge axi_tclk);
      if (tx_axis_tvalid && stalled && {tx_axis_tlast, tx_axis_tdata} !== held) stall_err++;
      if (gap_on && tx_axis_tvalid) begin
        last_gap = idle_run;
        gap_on = 1'b0;
      end
      if (!tx_axis_tvalid) idle_run++;
      if (tx_axis_tvalid && tx_axis_tready) begin
        out_q.push_back({tx_axis_tlast, tx_axis_tdata});
        if (tx_axis_tlast) begin
          frames_done++;
          gap_on = 1'b1;
          idle_run = 0;
        end
      end
      stalled = tx_axis_tvalid & !tx_axis_tready;
      held = {tx_axis_tlast, tx_axis_tdata};
      @(posedge axi_tclk);
      #1;
      tx_axis_tready = sink_mode == 0 ? 1'b1 : sink_mode == 1 ? ~tx_axis_tready : 1'b0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge axi_tclk);
    #1;
  endtask
  task automatic send_desc(input logic [15:0] l);
    int k;
    k = 0;
    desc_len = l;
    desc_valid = 1'b1;
    do begin
      @(negedge axi_tclk);
      k++;
    end while (!desc_ready && k < 300);
    chk("desc_handshake", desc_ready, 1);
    @(posedge axi_tclk);
    #1;
    desc_valid = 1'b0;
  endtask
  task automatic wait_frames(input int target);
    int k;
    k = 0;
    while (frames_done < target && k < 3000) begin
      @(negedge axi_tclk);
      k++;
    end
    chk("frame_done", frames_done, target);
  endtask
  task automatic build_hdr(input logic [15:0] l, input logic [15:0] c);
    logic [47:0] d, s;
    d = 48'hda0102030405;
    s = 48'h5a0102030405;
    exp_q = {};
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, d[47-8*i -: 8]});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, s[47-8*i -: 8]});
    exp_q.push_back({1'b0, l[7:0]});
    exp_q.push_back({1'b0, l[15:8]});
    exp_q.push_back({1'b0, c[7:0]});
    exp_q.push_back({l == 16'd0, c[15:8]});
  endtask
  task automatic cmp_frame(input string tag);
    int nbad, n;
    nbad = 0;
    chk({tag, "_len"}, out_q.size(), exp_q.size());
    n = out_q.size() < exp_q.size() ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) nbad++;
    chk({tag, "_bad_bytes"}, nbad, 0);
    out_q = {};
  endtask
  task automatic do_reset();
    @(negedge axi_tclk);
    axi_tresetn = 1'b0;
    desc_valid = 1'b0;
    src_q = {};
    tick(3);
    axi_tresetn = 1'b1;
    tick(1);
    out_q = {};
  endtask
  initial begin : stim
    int target;
    tick(3);
    chk("rst_tvalid", tx_axis_tvalid, 0);
    chk("rst_desc_ready", desc_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    axi_tresetn = 1'b1;
    tick(2);
    chk("idle_desc_ready", desc_ready, 1);
    // 1: basic frame
    src_q = {9'h0a1, 9'h0a2, 9'h0a3, 9'h1a4};
    send_desc(16'd4);
    wait_frames(1);
    build_hdr(16'd4, 16'd0);
    exp_q.push_back(9'h0a1);
    exp_q.push_back(9'h0a2);
    exp_q.push_back(9'h0a3);
    exp_q.push_back(9'h1a4);
    cmp_frame("basic");
    tick(2);
    chk("basic_count", frame_count, 1);
    chk("basic_len_err", len_err, 0);
    // 2: backpressure with toggling tready
    sink_mode = 1;
    src_q = {9'h0a1, 9'h0a2, 9'h0a3, 9'h1a4};
    send_desc(16'd4);
    wait_frames(2);
    build_hdr(16'd4, 16'd1);
    exp_q.push_back(9'h0a1);
    exp_q.push_back(9'h0a2);
    exp_q.push_back(9'h0a3);
    exp_q.push_back(9'h1a4);
    cmp_frame("bp");
    chk("bp_gap_ge12", last_gap >= 12, 1);
    chk("bp_stable", stall_err, 0);
    tick(2);
    chk("bp_count", frame_count, 2);
    // 3: early tlast pads with zeros and leaves later input untouched
    sink_mode = 0;
    src_q = {9'h0b1, 9'h1b2, 9'h0dd};
    send_desc(16'd6);
    wait_frames(3);
    build_hdr(16'd6, 16'd2);
    exp_q.push_back(9'h0b1);
    exp_q.push_back(9'h0b2);
    repeat (3) exp_q.push_back(9'h000);
    exp_q.push_back(9'h100);
    cmp_frame("early");
    tick(2);
    chk("early_len_err", len_err, 1);
    chk("early_src_left", src_q.size(), 1);
    do_reset();
    chk("rst2_len_err", len_err, 0);
    chk("rst2_count", frame_count, 0);
    // 4: oversize descriptor clamps to 1024 and drains the excess
    for (int i = 0; i < 1024; i++) src_q.push_back({1'b0, 8'(i)});
    src_q.push_back(9'h0ee);
    src_q.push_back(9'h0ee);
    src_q.push_back(9'h1ef);
    target = frames_done + 1;
    send_desc(16'd2000);
    wait_frames(target);
    build_hdr(16'd1024, 16'd0);
    for (int i = 0; i < 1024; i++) exp_q.push_back({i == 1023, 8'(i)});
    cmp_frame("oversize");
    tick(5);
    chk("oversize_drained", src_q.size(), 0);
    chk("oversize_len_err", len_err, 1);
    chk("oversize_count", frame_count, 1);
    // 5: zero-length frame at counter wrap
    force dut.frame_cnt = 16'hffff;
    tick(1);
    release dut.frame_cnt;
    tick(1);
    chk("wrap_preload", frame_count, 16'hffff);
    target = frames_done + 1;
    send_desc(16'd0);
    wait_frames(target);
    build_hdr(16'd0, 16'hffff);
    cmp_frame("zero_wrap");
    tick(2);
    chk("wrap_count", frame_count, 0);
    // 6: asynchronous reset mid-DATA
    for (int i = 0; i < 8; i++) src_q.push_back({i == 7, 8'h30 + 8'(i)});
    send_desc(16'd8);
    begin
      int k;
      k = 0;
      while (out_q.size() < 17 && k < 200) begin
        @(negedge axi_tclk);
        k++;
      end
      chk("areset_reach_data", out_q.size() >= 17, 1);
    end
    sink_mode = 2;
    tick(3);
    chk("areset_pre_tvalid", tx_axis_tvalid, 1);
    chk("areset_pre_busy", busy, 1);
    @(negedge axi_tclk);
    #1;
    axi_tresetn = 1'b0;
    #1;
    chk("areset_tvalid", tx_axis_tvalid, 0);
    chk("areset_desc_ready", desc_ready, 0);
    chk("areset_busy", busy, 0);
    tick(2);
    src_q = {};
    sink_mode = 0;
    tick(2);
    out_q = {};
    axi_tresetn = 1'b1;
    tick(1);
    src_q = {9'h1c1};
    target = frames_done + 1;
    send_desc(16'd1);
    wait_frames(target);
    build_hdr(16'd1, 16'd0);
    exp_q.push_back(9'h1c1);
    cmp_frame("after_reset");
    tick(2);
    chk("after_reset_count", frame_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
